debug_run_sched: RTL

- Command scheduler for the debug unit.
- Decodes host command bytes arriving from the UART receiver and sequences the pipeline in one of two modes: continuous run until halt, or single-step.
- After each run or step it triggers the register/memory dump sender, counts executed clocks and signals completion.
- Sits between the UART RX path, the pipeline step enable and the dump send unit.

---
 rtl/debug_run_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/debug_run_sched.sv
// Debug-unit command scheduler: decodes host bytes into continuous run or single-step
// sequencing, triggers a dump after each, counts executed clocks. Optional: RUN_WATCHDOG_EN.
module debug_run_sched #(
    parameter logic [7:0] CMD_RUN  = 8'h63,
    parameter logic [7:0] CMD_STEP = 8'h73,
    parameter logic [7:0] CMD_NEXT = 8'h6E,
    parameter logic [7:0] CMD_EXIT = 8'h65,
    parameter int         CNT_W    = 32
`ifdef RUN_WATCHDOG_EN
    ,
    parameter logic [CNT_W-1:0] MAX_CYCLES = 32'd100000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_halt,
    input  logic             i_send_done,
    output logic             o_step,
    output logic             o_send_start,
    output logic             o_done,
    output logic             o_err,
    output logic             o_busy,
    output logic             o_step_mode,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_clk_count
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RUN       = 4'd1,
        RUN_SEND  = 4'd2,
        RUN_WAIT  = 4'd3,
        DONE      = 4'd4,
        STEP_IDLE = 4'd5,
        STEP_EXEC = 4'd6,
        STEP_SEND = 4'd7,
        STEP_WAIT = 4'd8
    } state_t;

    state_t state, state_nxt;
    logic   clr_cnt;
    logic   wd_trip;

`ifdef RUN_WATCHDOG_EN
    assign wd_trip = (state == RUN) && !i_halt && (o_clk_count == MAX_CYCLES);
`else
    assign wd_trip = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        clr_cnt      = 1'b0;
        o_step       = 1'b0;
        o_send_start = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_busy       = 1'b0;
        o_step_mode  = 1'b0;
        case (state)
            IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_RUN) begin
                        state_nxt = RUN;
                        clr_cnt   = 1'b1;
                    end else if (i_rx_data == CMD_STEP) begin
                        state_nxt = STEP_IDLE;
                        clr_cnt   = 1'b1;
                    end else begin
                        o_err = 1'b1;
                    end
                end
            end
            RUN: begin
                o_busy = 1'b1;
                o_err  = i_rx_valid;
                // halt is sampled this cycle: an already-halted pipeline gets zero clocks
                if (i_halt || wd_trip) state_nxt = RUN_SEND;
                else                   o_step    = 1'b1;
            end
            RUN_SEND: begin
                o_busy       = 1'b1;
                o_err        = i_rx_valid;
                o_send_start = 1'b1;
                state_nxt    = RUN_WAIT;
            end
            RUN_WAIT: begin
                o_busy = 1'b1;
                o_err  = i_rx_valid;
                if (i_send_done) state_nxt = DONE;
            end
            DONE: begin
                o_busy    = 1'b1;
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            STEP_IDLE: begin
                o_step_mode = 1'b1;
                if (i_rx_valid) begin
                    if      (i_rx_data == CMD_NEXT) state_nxt = STEP_EXEC;
                    else if (i_rx_data == CMD_EXIT) state_nxt = DONE;
                    else                            o_err     = 1'b1;
                end
            end
            STEP_EXEC: begin
                o_busy      = 1'b1;
                o_step_mode = 1'b1;
                o_err       = i_rx_valid;
                o_step      = 1'b1;
                state_nxt   = STEP_SEND;
            end
            STEP_SEND: begin
                o_busy       = 1'b1;
                o_step_mode  = 1'b1;
                o_err        = i_rx_valid;
                o_send_start = 1'b1;
                state_nxt    = STEP_WAIT;
            end
            STEP_WAIT: begin
                o_busy      = 1'b1;
                o_step_mode = 1'b1;
                o_err       = i_rx_valid;
                if (i_send_done) state_nxt = i_halt ? DONE : STEP_IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)         o_clk_count <= '0;
        else if (clr_cnt) o_clk_count <= '0;
        else if (o_step)  o_clk_count <= o_clk_count + 1'b1;
    end

`ifdef RUN_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (!rst)         o_timeout <= 1'b0;
        else if (clr_cnt) o_timeout <= 1'b0;
        else if (wd_trip) o_timeout <= 1'b1;
    end
`else
    assign o_timeout = 1'b0;
`endif

endmodule
